// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - fixed-priority trap request source with request/service tracking
module interrupt_controller #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               nmi,
    input  logic               ecall,
    input  logic               ebreak,
    input  logic               tmr_irq,
    input  logic [NUM_IRQ-1:0] ext_irq,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               gie,
    input  logic               take,
    input  logic               mret,
    output logic               interruptF,
    output logic [2:0]         interSel,
    output logic [2:0]         intNum,
    output logic               in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    localparam logic [2:0] SEL_NMI    = 3'd0;
    localparam logic [2:0] SEL_ECALL  = 3'd1;
    localparam logic [2:0] SEL_EBREAK = 3'd2;
    localparam logic [2:0] SEL_TMR    = 3'd3;
    localparam logic [2:0] SEL_INT    = 3'd4;

    state_t     state_q;
    logic       intf_q, insvc_q;
    logic [2:0] sel_q, num_q;
    logic       nmi_prev_q, nmi_pend_q, ecall_pend_q, ebreak_pend_q;
    logic       nmi_pend_d, ecall_pend_d, ebreak_pend_d;

    logic               nmi_rise, take_ok, any_elig;
    logic [NUM_IRQ-1:0] int_vec;
    logic [2:0]         win_sel, win_num, int_idx;

    // Fresh pulses/edges count as eligible in the same cycle so simultaneous
    // arrivals are ordered purely by priority, not by capture path.
    always_comb begin
        nmi_rise = nmi & ~nmi_prev_q;
        take_ok  = (state_q == REQ) & take;
        int_vec  = ext_irq & irq_en & {NUM_IRQ{gie}};

        int_idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (int_vec[i]) int_idx = 3'(i);
        end

        any_elig = 1'b1;
        win_num  = 3'd0;
        if (nmi_pend_q | nmi_rise)           win_sel = SEL_NMI;
        else if (ecall_pend_q | ecall)       win_sel = SEL_ECALL;
        else if (ebreak_pend_q | ebreak)     win_sel = SEL_EBREAK;
        else if (tmr_irq & gie)              win_sel = SEL_TMR;
        else if (|int_vec) begin
            win_sel = SEL_INT;
            win_num = int_idx;
        end else begin
            win_sel  = sel_q;
            any_elig = 1'b0;
        end

        // set wins over clear when a new pulse lands on the take cycle
        nmi_pend_d    = (nmi_pend_q    & ~(take_ok & (sel_q == SEL_NMI)))    | nmi_rise;
        ecall_pend_d  = (ecall_pend_q  & ~(take_ok & (sel_q == SEL_ECALL)))  | ecall;
        ebreak_pend_d = (ebreak_pend_q & ~(take_ok & (sel_q == SEL_EBREAK))) | ebreak;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_prev_q    <= 1'b0;
            nmi_pend_q    <= 1'b0;
            ecall_pend_q  <= 1'b0;
            ebreak_pend_q <= 1'b0;
        end else begin
            nmi_prev_q    <= nmi;
            nmi_pend_q    <= nmi_pend_d;
            ecall_pend_q  <= ecall_pend_d;
            ebreak_pend_q <= ebreak_pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            intf_q  <= 1'b0;
            insvc_q <= 1'b0;
            sel_q   <= 3'd0;
            num_q   <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_elig) begin
                        sel_q   <= win_sel;
                        num_q   <= win_num;
                        intf_q  <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (take) begin
                        intf_q  <= 1'b0;
                        insvc_q <= 1'b1;
                        state_q <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (mret) begin
                        insvc_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    intf_q  <= 1'b0;
                    insvc_q <= 1'b0;
                end
            endcase
        end
    end

    assign interruptF = intf_q;
    assign interSel   = sel_q;
    assign intNum     = num_q;
    assign in_service = insvc_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed scoreboard bench for interrupt_controller
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       rst_n, nmi, ecall, ebreak, tmr_irq, gie, take, mret;
    logic [7:0] ext_irq, irq_en;
    logic       interruptF, in_service;
    logic [2:0] interSel, intNum;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic       f;
        logic [2:0] sel;
        logic [2:0] num;
        logic       svc;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    interrupt_controller #(.NUM_IRQ(8)) dut (
        .clk(clk), .rst_n(rst_n), .nmi(nmi), .ecall(ecall), .ebreak(ebreak),
        .tmr_irq(tmr_irq), .ext_irq(ext_irq), .irq_en(irq_en), .gie(gie),
        .take(take), .mret(mret), .interruptF(interruptF), .interSel(interSel),
        .intNum(intNum), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string field, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic f, input logic [2:0] sel,
                        input logic [2:0] num, input logic svc);
        exp_t e;
        e.f = f; e.sel = sel; e.num = num; e.svc = svc;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        cmp(t, "interruptF", int'(interruptF), int'(e.f));
        cmp(t, "interSel",   int'(interSel),   int'(e.sel));
        cmp(t, "intNum",     int'(intNum),     int'(e.num));
        cmp(t, "in_service", int'(in_service), int'(e.svc));
    endtask

    // One clock with the currently driven inputs, then compare against the expectation.
    task automatic cyc(input string tag, input logic f, input logic [2:0] sel,
                       input logic [2:0] num, input logic svc);
        push(tag, f, sel, num, svc);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        rst_n = 1'b0; nmi = 0; ecall = 0; ebreak = 0; tmr_irq = 0; gie = 0;
        take = 0; mret = 0; ext_irq = 8'h00; irq_en = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        push("reset_hold", 0, 3'd0, 3'd0, 0);
        pop_check();
        rst_n = 1'b1;
        cyc("reset_idle", 0, 3'd0, 3'd0, 0);

        ext_irq = 8'b0010_0100; irq_en = 8'hFF; gie = 1;
        cyc("int_req", 1, 3'd4, 3'd2, 0);
        cyc("int_hold", 1, 3'd4, 3'd2, 0);
        take = 1;
        cyc("int_take", 0, 3'd4, 3'd2, 1);
        take = 0; ext_irq = 8'b0010_0000;
        cyc("int_svc", 0, 3'd4, 3'd2, 1);
        mret = 1;
        cyc("int_mret", 0, 3'd4, 3'd2, 0);
        mret = 0;
        cyc("int_next", 1, 3'd4, 3'd5, 0);
        take = 1;
        cyc("int5_take", 0, 3'd4, 3'd5, 1);
        take = 0; ext_irq = 8'h00; mret = 1;
        cyc("int5_mret", 0, 3'd4, 3'd5, 0);
        mret = 0;
        cyc("idle_hold", 0, 3'd4, 3'd5, 0);

        ext_irq = 8'h01;
        cyc("rst_req", 1, 3'd4, 3'd0, 0);
        #2 rst_n = 1'b0;
        #1;
        push("async_rst", 0, 3'd0, 3'd0, 0);
        pop_check();
        ext_irq = 8'h00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("post_rst", 0, 3'd0, 3'd0, 0);

        nmi = 1; ecall = 1; tmr_irq = 1;
        cyc("multi_nmi", 1, 3'd0, 3'd0, 0);
        ecall = 0; take = 1;
        cyc("nmi_take", 0, 3'd0, 3'd0, 1);
        take = 0; mret = 1;
        cyc("nmi_mret", 0, 3'd0, 3'd0, 0);
        mret = 0;
        cyc("multi_ecall", 1, 3'd1, 3'd0, 0);
        take = 1;
        cyc("ecall_take", 0, 3'd1, 3'd0, 1);
        take = 0; mret = 1;
        cyc("ecall_mret", 0, 3'd1, 3'd0, 0);
        mret = 0;
        cyc("multi_tmr", 1, 3'd3, 3'd0, 0);
        take = 1;
        cyc("tmr_take", 0, 3'd3, 3'd0, 1);
        take = 0; tmr_irq = 0; mret = 1;
        cyc("tmr_mret", 0, 3'd3, 3'd0, 0);
        mret = 0; nmi = 0;
        cyc("multi_idle", 0, 3'd3, 3'd0, 0);

        gie = 0; tmr_irq = 1; ext_irq = 8'hFF;
        cyc("gie_off_a", 0, 3'd3, 3'd0, 0);
        cyc("gie_off_b", 0, 3'd3, 3'd0, 0);
        ebreak = 1;
        cyc("ebreak_req", 1, 3'd2, 3'd0, 0);
        ebreak = 0; take = 1;
        cyc("ebreak_take", 0, 3'd2, 3'd0, 1);
        take = 0; mret = 1;
        cyc("ebreak_mret", 0, 3'd2, 3'd0, 0);
        mret = 0;
        cyc("gie_off_c", 0, 3'd2, 3'd0, 0);
        tmr_irq = 0; ext_irq = 8'h00; gie = 1;

        ext_irq = 8'b0000_1000;
        cyc("frz_req", 1, 3'd4, 3'd3, 0);
        ext_irq = 8'h00; nmi = 1;
        cyc("frz_hold", 1, 3'd4, 3'd3, 0);
        take = 1;
        cyc("frz_take", 0, 3'd4, 3'd3, 1);
        take = 0; mret = 1;
        cyc("frz_mret", 0, 3'd4, 3'd3, 0);
        mret = 0;
        cyc("frz_nmi", 1, 3'd0, 3'd0, 0);
        take = 1;
        cyc("frz_nmi_take", 0, 3'd0, 3'd0, 1);
        take = 0; nmi = 0; mret = 1;
        cyc("frz_nmi_mret", 0, 3'd0, 3'd0, 0);
        mret = 0;

        ebreak = 1;
        cyc("svc_req", 1, 3'd2, 3'd0, 0);
        ebreak = 0; take = 1;
        cyc("svc_take", 0, 3'd2, 3'd0, 1);
        take = 0; ecall = 1; mret = 1;
        cyc("mret_ecall", 0, 3'd2, 3'd0, 0);
        ecall = 0; mret = 0;
        cyc("mret_ecall_req", 1, 3'd1, 3'd0, 0);
        take = 1; ecall = 1;
        cyc("take_repulse", 0, 3'd1, 3'd0, 1);
        take = 0; ecall = 0; mret = 1;
        cyc("repulse_mret", 0, 3'd1, 3'd0, 0);
        mret = 0;
        cyc("repulse_req", 1, 3'd1, 3'd0, 0);
        take = 1;
        cyc("repulse_take", 0, 3'd1, 3'd0, 1);
        take = 0; mret = 1;
        cyc("repulse_done", 0, 3'd1, 3'd0, 0);
        mret = 0;
        cyc("final_idle", 0, 3'd1, 3'd0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Upstream feeder of the interrupt address generator.
- Collects NMI, ECALL, EBREAK, timer and external IRQ sources, and latches or samples them.
- Applies global and per-line enables and arbitrates by fixed priority.
- Presents one registered request (interruptF, interSel, intNum) to the PC/trap logic, holds it until the core takes the trap, then tracks in-service state until mret.

Parameters:
- NUM_IRQ, 8, number of external interrupt lines (1..8); intNum width fixed at 3.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- nmi  in  1  non-maskable interrupt request; rising-edge sensitive.
- ecall  in  1  one-cycle pulse from decode when an ECALL is committed.
- ebreak  in  1  one-cycle pulse from decode when an EBREAK is committed.
- tmr_irq  in  1  timer interrupt, level.
- ext_irq  in  NUM_IRQ  external interrupt lines, level, bit i = line i.
- irq_en  in  NUM_IRQ  per-line enable mask from CSR.
- gie  in  1  global interrupt enable from CSR; gates TMR and INT only.
- take  in  1  PC logic has redirected to the trap vector this cycle.
- mret  in  1  one-cycle pulse when the trap-return instruction commits.
- interruptF  out  1  trap request valid.
- interSel  out  3  source code: NMI=3'd0, ECALL=3'd1, EBREAK=3'd2, TMR=3'd3, INT=3'd4.
- intNum  out  3  external line index; valid when interSel=INT, else 0.
- in_service  out  1  a trap handler is executing.

Behaviour:
- Reset, asynchronous and active-low: state=IDLE; interruptF=0, interSel=0, intNum=0, in_service=0.
  - The nmi edge-detect register, nmi_pend, ecall_pend and ebreak_pend all clear.
  - Assertion mid-request or mid-service aborts immediately. No request survives reset.
- Source capture, every cycle in every state:
  - nmi_pend set on a 0->1 transition of nmi, using a registered previous value.
  - ecall_pend set on an ecall pulse; ebreak_pend set on an ebreak pulse.
  - Each pending bit is sticky until its request is taken.
  - tmr_irq and ext_irq are not latched. The device holds the line until its handler clears it.
- Eligibility:
  - NMI, ECALL and EBREAK are always eligible.
  - TMR is eligible when tmr_irq & gie.
  - Line i is eligible when ext_irq[i] & irq_en[i] & gie.
- Priority: NMI > ECALL > EBREAK > TMR > INT. Among INT lines, the lowest index wins.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if any source is eligible, register the winner into interSel/intNum, set interruptF=1 and go to REQ. Latency is one cycle: a source eligible at edge N gives interruptF=1 after edge N+1.
  - REQ: interruptF=1. interSel and intNum are frozen even if the level source drops or a higher-priority source arrives; the request is never withdrawn.
    - On take=1: interruptF=0, clear the matching pending bit (NMI/ECALL/EBREAK), in_service=1, go to SERVICE.
  - SERVICE: no nesting; new sources stay pending or level-held. in_service=1.
    - On mret=1: in_service=0, go to IDLE. Arbitration resumes on the next cycle, so back-to-back traps are 1 cycle apart minimum.
- take outside REQ and mret outside SERVICE are ignored.
- Same-cycle events:
  - take together with a new pulse of the source being taken: the new pulse re-sets its pending bit, because set wins over clear.
  - take together with any other new source: that source stays pending.
  - mret together with a new source: the source is recorded and requested from IDLE on the next cycle.
- In IDLE with no eligible source, interSel and intNum hold their last values while interruptF=0.
- When NUM_IRQ<8, intNum is zero-extended.

Test Plan:
- Reset and no sources: interruptF=0, in_service=0, interSel=0. Pulse rst_n low while in REQ: outputs return to 0 asynchronously.
- ext_irq=8'b0010_0100, irq_en=8'hFF, gie=1:
  - Next cycle interruptF=1, interSel=4, intNum=2.
  - take -> in_service=1.
  - Clear line 2, then mret -> next request is intNum=5.
- Same cycle: nmi rising edge, ecall pulse and tmr_irq=1. Serve each with take/mret:
  - Grants in order: interSel=0, then 1, then 3.
  - In-order service of the timer requires tmr_irq=1 and gie=1 throughout.
- gie=0, tmr_irq=1, ext_irq=8'hFF:
  - interruptF stays 0.
  - An ebreak pulse still gives interSel=2.
- In REQ with interSel=4/intNum=3, drop ext_irq[3] and assert nmi: interSel=4 and intNum=3 stay frozen. After take and mret, interSel=0.
- During SERVICE, pulse ecall together with mret: IDLE, then interruptF=1 with interSel=1 one cycle later.
